// File: rtl/axil_regfile.sv
// AXI4-Lite slave register bank with byte-strobed writes and a flat register view.
// Optional read-only ID register in the top slot: define AXIL_REGFILE_ID_EN.
module axil_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hD5A1_0001
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          awaddr_i,
  input  logic [2:0]                     awprot_i,
  input  logic                           awvalid_i,
  output logic                           awready_o,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic                           wvalid_i,
  output logic                           wready_o,
  output logic [1:0]                     bresp_o,
  output logic                           bvalid_o,
  input  logic                           bready_i,
  input  logic [ADDR_WIDTH-1:0]          araddr_i,
  input  logic [2:0]                     arprot_i,
  input  logic                           arvalid_i,
  output logic                           arready_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [1:0]                     rresp_o,
  output logic                           rvalid_o,
  input  logic                           rready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] NREGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t ws_q, ws_d;
  rstate_t rs_q, rs_d;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] view [NUM_REGS];

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SW-1:0]         w_strb;

  logic                  aw_fire, w_fire, ar_fire, commit, wr_ok;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic [SW-1:0]         wsb;
  logic [IW-1:0]         widx, ridx;

  logic unused_prot;
  assign unused_prot = ^{awprot_i, arprot_i};

  function automatic logic hit(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> LSB) < NREGS_A);
  endfunction

  function automatic logic [IW-1:0] index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - BASE_ADDR) >> LSB;
    return off[IW-1:0];
  endfunction

  // Architectural view: the ID slot overrides storage when enabled
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) view[k] = regs_q[k];
`ifdef AXIL_REGFILE_ID_EN
    view[NUM_REGS-1] = ID_VALUE;
`endif
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = view[k];
  end

  assign awready_o = !aw_held && (ws_q == W_COLLECT);
  assign wready_o  = !w_held && (ws_q == W_COLLECT);
  assign bvalid_o  = (ws_q == W_RESP);
  assign arready_o = (rs_q == R_IDLE);
  assign rvalid_o  = (rs_q == R_RESP);

  assign aw_fire = awvalid_i && awready_o;
  assign w_fire  = wvalid_i && wready_o;
  assign ar_fire = arvalid_i && arready_o;

  assign wa  = aw_held ? aw_addr : awaddr_i;
  assign wd  = w_held ? w_data : wdata_i;
  assign wsb = w_held ? w_strb : wstrb_i;
  assign widx = index(wa);
  assign ridx = index(araddr_i);

  assign commit = (ws_q == W_COLLECT) &&
                  (aw_held || aw_fire) && (w_held || w_fire);

`ifdef AXIL_REGFILE_ID_EN
  assign wr_ok = hit(wa) && (widx != LAST);
`else
  assign wr_ok = hit(wa);
`endif

  always_comb begin
    ws_d = ws_q;
    unique case (ws_q)
      W_COLLECT: if (commit) ws_d = W_RESP;
      W_RESP:    if (bready_i) ws_d = W_COLLECT;
    endcase
  end

  always_comb begin
    rs_d = rs_q;
    unique case (rs_q)
      R_IDLE: if (arvalid_i) rs_d = R_RESP;
      R_RESP: if (rready_i) rs_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ws_q <= W_COLLECT;
      rs_q <= R_IDLE;
    end else begin
      ws_q <= ws_d;
      rs_q <= rs_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bresp_o <= OKAY;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_addr <= awaddr_i;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= wdata_i;
        w_strb <= wstrb_i;
      end
      if (commit) bresp_o <= wr_ok ? OKAY : SLVERR;
      if ((ws_q == W_RESP) && bready_i) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else if (commit && wr_ok) begin
      for (int b = 0; b < SW; b++)
        if (wsb[b]) regs_q[widx][b*8 +: 8] <= wd[b*8 +: 8];
    end
  end

  // Captured from pre-commit contents, so a same-edge write is not visible
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= '0;
      rresp_o <= OKAY;
    end else if (ar_fire) begin
      rdata_o <= hit(araddr_i) ? view[ridx] : '0;
      rresp_o <= hit(araddr_i) ? OKAY : SLVERR;
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Directed table-driven bench for axil_regfile (default parameters).
// Build with +define+AXIL_REGFILE_ID_EN to exercise the ID register variant.
module tb_axil_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [511:0] regs;

  int checks = 0;
  int failures = 0;

`ifdef AXIL_REGFILE_ID_EN
  localparam logic [31:0] LAST_EXP = 32'hD5A1_0001;
  localparam logic [1:0]  LAST_WR_RESP = 2'b10;
`else
  localparam logic [31:0] LAST_EXP = 32'h0;
  localparam logic [1:0]  LAST_WR_RESP = 2'b00;
`endif

  axil_regfile dut (
    .clk_i(clk), .rst_i(rst),
    .awaddr_i(awaddr), .awprot_i(awprot),
    .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb),
    .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arprot_i(arprot),
    .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp),
    .rvalid_o(rvalid), .rready_i(rready),
    .regs_o(regs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_at(input int k);
    return regs[k*32 +: 32];
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] r);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("wr_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid_latency", bvalid, 1);
    r = bresp;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] r);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("rd_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd_rvalid_latency", rvalid, 1);
    d = rdata;
    r = rresp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    tv[0]  = '{1'b0, 32'h0C, 32'h0,         4'h0, 2'b00, 32'h0};
    tv[1]  = '{1'b1, 32'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
    tv[2]  = '{1'b1, 32'h0C, 32'hA5A5_1234, 4'h5, 2'b00, 32'h0};
    tv[3]  = '{1'b0, 32'h0C, 32'h0,         4'h0, 2'b00, 32'hFFA5_FF34};
    tv[4]  = '{1'b1, 32'h40, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
    tv[5]  = '{1'b0, 32'h40, 32'h0,         4'h0, 2'b10, 32'h0};
    tv[6]  = '{1'b0, 32'h0C, 32'h0,         4'h0, 2'b00, 32'hFFA5_FF34};
    tv[7]  = '{1'b1, 32'h04, 32'hDEAD_BEEF, 4'h0, 2'b00, 32'h0};
    tv[8]  = '{1'b0, 32'h04, 32'h0,         4'h0, 2'b00, 32'h0};
    tv[9]  = '{1'b1, 32'h07, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
    tv[10] = '{1'b0, 32'h04, 32'h0,         4'h0, 2'b00, 32'h1122_3344};
    tv[11] = '{1'b1, 32'h08, 32'hAB00_00CD, 4'h8, 2'b00, 32'h0};
    tv[12] = '{1'b0, 32'h08, 32'h0,         4'h0, 2'b00, 32'hAB00_0000};
    tv[13] = '{1'b1, 32'h3C, 32'h0,         4'hF, LAST_WR_RESP, 32'h0};
    tv[14] = '{1'b0, 32'h3C, 32'h0,         4'h0, 2'b00, LAST_EXP};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_reg3", reg_at(3), 0);
    chk("rst_reg_last", reg_at(15), LAST_EXP);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", awready, 1);

    for (int i = 0; i < 15; i++) begin
      if (tv[i].wr) begin
        do_write(tv[i].addr, tv[i].data, tv[i].strb, r);
        chk($sformatf("tv%0d_bresp", i), r, tv[i].resp);
      end else begin
        do_read(tv[i].addr, d, r);
        chk($sformatf("tv%0d_rresp", i), r, tv[i].resp);
        chk($sformatf("tv%0d_rdata", i), d, tv[i].rdata);
      end
    end
    chk("regs_o_idx3", reg_at(3), 32'hFFA5_FF34);

    // Skewed W then AW, bready held low
    @(negedge clk);
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    chk("skew_wready_c1", wready, 0);
    chk("skew_bvalid_c1", bvalid, 0);
    @(negedge clk);
    chk("skew_wready_c2", wready, 0);
    @(negedge clk);
    chk("skew_wready_c3", wready, 0);
    chk("skew_no_commit", reg_at(5), 0);
    awaddr = 32'h14; awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    chk("skew_bvalid_c4", bvalid, 1);
    chk("skew_reg5", reg_at(5), 32'h0BAD_F00D);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("skew_hold_bvalid%0d", c), bvalid, 1);
      chk($sformatf("skew_hold_bresp%0d", c), bresp, 0);
      chk($sformatf("skew_hold_wready%0d", c), wready, 0);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("skew_bvalid_done", bvalid, 0);
    chk("skew_wready_back", wready, 1);

    // Same-edge read and write on index 2
    do_write(32'h08, 32'h1, 4'hF, r);
    @(negedge clk);
    awaddr = 32'h08; wdata = 32'h2; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_rvalid", rvalid, 1);
    chk("same_rdata_old", rdata, 32'h1);
    chk("same_bvalid", bvalid, 1);
    @(negedge clk);
    chk("same_rdata_stable", rdata, 32'h1);
    rready = 1'b1;
    @(posedge clk);
    do_read(32'h08, d, r);
    chk("same_next_rdata", d, 32'h2);

    // Reset mid-transaction drops a held W beat
    @(negedge clk);
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_wready", wready, 1);
    chk("mid_rst_reg3", reg_at(3), 0);
    rst = 1'b0;
    awaddr = 32'h0; awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    @(negedge clk);
    chk("mid_no_commit_bvalid", bvalid, 0);
    chk("mid_no_commit_reg0", reg_at(0), 0);
    wdata = 32'h55; wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
    chk("mid_commit_bvalid", bvalid, 1);
    chk("mid_commit_reg0", reg_at(0), 32'h55);
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
